// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control for RV32I with an iterative RV32M multiply/divide sequencer.
// Base ops decode to alu_select with one cycle of latency. M-ops run bit-serially
// and hold stall until their result is posted on md_result.
module alu_ctrl_muldiv #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned SEL_W    = 4,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [1:0]       alu_op,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic             flush,
    output logic [SEL_W-1:0] alu_select,
    output logic             sel_valid,
    output logic             illegal,
    output logic             stall,
    output logic             md_done,
    output logic [XLEN-1:0]  md_result
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN + 1;

    localparam logic [SEL_W-1:0] SEL_ADD  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_SUB  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_SLL  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_SRL  = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_SRA  = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_XOR  = SEL_W'(5);
    localparam logic [SEL_W-1:0] SEL_OR   = SEL_W'(6);
    localparam logic [SEL_W-1:0] SEL_AND  = SEL_W'(7);
    localparam logic [SEL_W-1:0] SEL_SLT  = SEL_W'(8);
    localparam logic [SEL_W-1:0] SEL_SLTU = SEL_W'(9);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_M       = 7'b0000001;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign f3           = instr[14:12];
    assign f7           = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [2:0]       f3_q, f3_d;
    logic             neg_q, neg_d;
    logic             special_q, special_d;
    logic             wait_q, wait_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             illegal_q, illegal_d;
    logic             stall_q, stall_d;
    logic             md_done_q, md_done_d;
    logic [XLEN-1:0]  md_result_q, md_result_d;

    logic [SEL_W-1:0] dec_sel;
    logic             dec_ok;
    logic             dec_m;

    // Decode of the instruction fields into an ALU select / M-op / illegal
    always_comb begin
        dec_sel = SEL_ADD;
        dec_ok  = 1'b0;
        dec_m   = 1'b0;
        unique case (alu_op)
            2'b00: begin
                if (opcode == OPC_LOAD && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                                           f3 == 3'b100 || f3 == 3'b101)) begin
                    dec_ok = 1'b1;
                end else if (opcode == OPC_STORE && (f3 == 3'b000 || f3 == 3'b001 ||
                                                     f3 == 3'b010)) begin
                    dec_ok = 1'b1;
                end
            end
            2'b01: begin
                if (opcode == OPC_BRANCH && f3 != 3'b010 && f3 != 3'b011) begin
                    dec_sel = SEL_SUB;
                    dec_ok  = 1'b1;
                end
            end
            2'b10: begin
                if (opcode == OPC_OP) begin
                    if (f7 == F7_BASE) begin
                        dec_ok = 1'b1;
                        unique case (f3)
                            3'b000:  dec_sel = SEL_ADD;
                            3'b001:  dec_sel = SEL_SLL;
                            3'b010:  dec_sel = SEL_SLT;
                            3'b011:  dec_sel = SEL_SLTU;
                            3'b100:  dec_sel = SEL_XOR;
                            3'b101:  dec_sel = SEL_SRL;
                            3'b110:  dec_sel = SEL_OR;
                            default: dec_sel = SEL_AND;
                        endcase
                    end else if (f7 == F7_ALT && f3 == 3'b000) begin
                        dec_sel = SEL_SUB;
                        dec_ok  = 1'b1;
                    end else if (f7 == F7_ALT && f3 == 3'b101) begin
                        dec_sel = SEL_SRA;
                        dec_ok  = 1'b1;
                    end else if (f7 == F7_M && ENABLE_M) begin
                        dec_m = 1'b1;
                    end
                end else if (opcode == OPC_OPIMM) begin
                    unique case (f3)
                        3'b000: begin dec_sel = SEL_ADD;  dec_ok = 1'b1; end
                        3'b010: begin dec_sel = SEL_SLT;  dec_ok = 1'b1; end
                        3'b011: begin dec_sel = SEL_SLTU; dec_ok = 1'b1; end
                        3'b100: begin dec_sel = SEL_XOR;  dec_ok = 1'b1; end
                        3'b110: begin dec_sel = SEL_OR;   dec_ok = 1'b1; end
                        3'b111: begin dec_sel = SEL_AND;  dec_ok = 1'b1; end
                        3'b001: begin
                            if (f7 == F7_BASE) begin
                                dec_sel = SEL_SLL;
                                dec_ok  = 1'b1;
                            end
                        end
                        default: begin
                            if (f7 == F7_BASE) begin
                                dec_sel = SEL_SRL;
                                dec_ok  = 1'b1;
                            end else if (f7 == F7_ALT) begin
                                dec_sel = SEL_SRA;
                                dec_ok  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    logic            is_div;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            res_neg;
    logic            div_zero, div_ovf, is_special;
    logic [XLEN-1:0] special_res;

    // Operand magnitudes, result sign and the divide special cases at accept time
    always_comb begin
        is_div      = f3[2];
        a_signed    = is_div ? ~f3[0] : (f3 == 3'b001 || f3 == 3'b010);
        b_signed    = is_div ? ~f3[0] : (f3 == 3'b001);
        a_neg       = a_signed & op_a[XLEN-1];
        b_neg       = b_signed & op_b[XLEN-1];
        // min_int negates to itself, which is already the correct unsigned magnitude
        a_mag       = a_neg ? -op_a : op_a;
        b_mag       = b_neg ? -op_b : op_b;
        res_neg     = (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero    = (op_b == '0);
        div_ovf     = ~f3[0] && (op_a == MIN_INT) && (op_b == '1);
        is_special  = is_div && (div_zero || div_ovf);
        special_res = '0;
        if (div_zero) begin
            special_res = f3[1] ? op_a : '1;
        end else begin
            special_res = f3[1] ? '0 : op_a;
        end
    end

    logic [XLEN:0]   mul_sum;
    logic [PW-1:0]   mul_next;
    logic [XLEN:0]   div_rem_s;
    logic [XLEN+1:0] div_trial;
    logic [PW-1:0]   div_next;

    // One shift-add multiply step and one restoring-divide step on {hi, lo}
    always_comb begin
        mul_sum   = p_q[PW-1:XLEN] + {1'b0, b_q};
        mul_next  = p_q[0] ? {1'b0, mul_sum, p_q[XLEN-1:1]}
                           : {1'b0, p_q[PW-1:XLEN], p_q[XLEN-1:1]};
        div_rem_s = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        div_trial = {1'b0, div_rem_s} - {2'b00, b_q};
        div_next  = div_trial[XLEN+1] ? {div_rem_s, p_q[XLEN-2:0], 1'b0}
                                      : {div_trial[XLEN:0], p_q[XLEN-2:0], 1'b1};
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   div_sel, div_res, fix_res;

    // Sign fix-up and result selection for the finishing cycle
    always_comb begin
        prod    = p_q[2*XLEN-1:0];
        prod_s  = neg_q ? -prod : prod;
        div_sel = f3_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
        div_res = neg_q ? -div_sel : div_sel;
        if (special_q) begin
            fix_res = p_q[XLEN-1:0];
        end else if (f3_q[2]) begin
            fix_res = div_res;
        end else if (f3_q == 3'b000) begin
            fix_res = prod_s[XLEN-1:0];
        end else begin
            fix_res = prod_s[2*XLEN-1:XLEN];
        end
    end

    logic accept;

    // Next-state and registered-output logic for decode and the M-engine FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        b_d         = b_q;
        f3_d        = f3_q;
        neg_d       = neg_q;
        special_d   = special_q;
        wait_d      = wait_q;
        sel_d       = sel_q;
        sel_valid_d = 1'b0;
        illegal_d   = 1'b0;
        md_done_d   = 1'b0;
        md_result_d = md_result_q;

        accept = in_valid && !flush && (state_q == ST_IDLE);

        if (accept) begin
            sel_d       = dec_m ? SEL_ADD : dec_sel;
            sel_valid_d = dec_ok;
            illegal_d   = !dec_ok && !dec_m;
        end

        if (flush) begin
            state_d = ST_IDLE;
            wait_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && dec_m) begin
                        f3_d      = f3;
                        neg_d     = res_neg;
                        b_d       = b_mag;
                        special_d = is_special;
                        if (is_special) begin
                            // Result is known up front; FIX waits one cycle before posting it
                            p_d     = PW'(special_res);
                            wait_d  = 1'b1;
                            state_d = ST_FIX;
                        end else begin
                            p_d     = PW'(a_mag);
                            cnt_d   = CNT_W'(XLEN - 1);
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    p_d = f3_q[2] ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (wait_q) begin
                        wait_d = 1'b0;
                    end else begin
                        md_done_d   = 1'b1;
                        md_result_d = fix_res;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        stall_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            b_q         <= '0;
            f3_q        <= '0;
            neg_q       <= 1'b0;
            special_q   <= 1'b0;
            wait_q      <= 1'b0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            stall_q     <= 1'b0;
            md_done_q   <= 1'b0;
            md_result_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            b_q         <= b_d;
            f3_q        <= f3_d;
            neg_q       <= neg_d;
            special_q   <= special_d;
            wait_q      <= wait_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            illegal_q   <= illegal_d;
            stall_q     <= stall_d;
            md_done_q   <= md_done_d;
            md_result_q <= md_result_d;
        end
    end

    assign alu_select = sel_q;
    assign sel_valid  = sel_valid_q;
    assign illegal    = illegal_q;
    assign stall      = stall_q;
    assign md_done    = md_done_q;
    assign md_result  = md_result_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: base decode, M-op results and latency,
// divide special cases, flush, back-to-back issue and asynchronous reset.
module tb_alu_ctrl_muldiv;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [1:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic [3:0]  alu_select;
    logic        sel_valid;
    logic        illegal;
    logic        stall;
    logic        md_done;
    logic [31:0] md_result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res = 32'h0;

    typedef struct packed {
        logic [6:0] f7;
        logic [2:0] f3;
        logic [6:0] opc;
        logic [1:0] op;
        logic [3:0] sel;
        logic       vld;
        logic       ill;
    } dec_vec_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [7:0]  lat;
    } md_vec_t;

    alu_ctrl_muldiv #(.XLEN(32), .SEL_W(4), .ENABLE_M(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .instr      (instr),
        .alu_op     (alu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .alu_select (alu_select),
        .sel_valid  (sel_valid),
        .illegal    (illegal),
        .stall      (stall),
        .md_done    (md_done),
        .md_result  (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // Present one instruction for exactly one clock edge; returns 1ns after that edge
    task automatic send(input logic [31:0] ins, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instr    = ins;
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Follow an M-op from 1ns after its accept edge until md_done (bounded)
    task automatic run_md(output int lat, output int stl, output logic [31:0] res);
        lat = -1;
        stl = 0;
        res = 32'hx;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (md_done === 1'b1) begin
                lat = k;
                res = md_result;
                break;
            end
            if (stall === 1'b1) stl++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({alu_select, sel_valid, illegal, stall, md_done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected 00",
                     {alu_select, sel_valid, illegal, stall, md_done});
        end
        checks++;
        if (md_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00000000", md_result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_base_decode();
        dec_vec_t v [21];
        v[0]  = '{7'b0000000, 3'b000, 7'b0110011, 2'b10, 4'd0, 1'b1, 1'b0};
        v[1]  = '{7'b0100000, 3'b101, 7'b0110011, 2'b10, 4'd4, 1'b1, 1'b0};
        v[2]  = '{7'b0100000, 3'b000, 7'b0110011, 2'b10, 4'd1, 1'b1, 1'b0};
        v[3]  = '{7'b0000000, 3'b011, 7'b0110011, 2'b10, 4'd9, 1'b1, 1'b0};
        v[4]  = '{7'b0100000, 3'b001, 7'b0110011, 2'b10, 4'd0, 1'b0, 1'b1};
        v[5]  = '{7'b0000000, 3'b110, 7'b0110011, 2'b10, 4'd6, 1'b1, 1'b0};
        v[6]  = '{7'b0000010, 3'b000, 7'b0110011, 2'b10, 4'd0, 1'b0, 1'b1};
        v[7]  = '{7'b0000000, 3'b101, 7'b0000011, 2'b00, 4'd0, 1'b1, 1'b0};
        v[8]  = '{7'b0000000, 3'b010, 7'b0100011, 2'b00, 4'd0, 1'b1, 1'b0};
        v[9]  = '{7'b0000000, 3'b100, 7'b0100011, 2'b00, 4'd0, 1'b0, 1'b1};
        v[10] = '{7'b0000000, 3'b101, 7'b1100011, 2'b01, 4'd1, 1'b1, 1'b0};
        v[11] = '{7'b0000000, 3'b011, 7'b1100011, 2'b01, 4'd0, 1'b0, 1'b1};
        v[12] = '{7'b0100000, 3'b101, 7'b0010011, 2'b10, 4'd4, 1'b1, 1'b0};
        v[13] = '{7'b0100000, 3'b001, 7'b0010011, 2'b10, 4'd0, 1'b0, 1'b1};
        v[14] = '{7'b0101010, 3'b111, 7'b0010011, 2'b10, 4'd7, 1'b1, 1'b0};
        v[15] = '{7'b0000000, 3'b000, 7'b0000011, 2'b10, 4'd0, 1'b0, 1'b1};
        v[16] = '{7'b0000000, 3'b000, 7'b0110011, 2'b11, 4'd0, 1'b0, 1'b1};
        v[17] = '{7'b1111111, 3'b010, 7'b0010011, 2'b10, 4'd8, 1'b1, 1'b0};
        v[18] = '{7'b0000000, 3'b100, 7'b0010011, 2'b10, 4'd5, 1'b1, 1'b0};
        v[19] = '{7'b0000000, 3'b101, 7'b0110011, 2'b10, 4'd3, 1'b1, 1'b0};
        v[20] = '{7'b0000000, 3'b001, 7'b0110011, 2'b10, 4'd2, 1'b1, 1'b0};
        for (int i = 0; i < 21; i++) begin
            send(mk(v[i].f7, v[i].f3, v[i].opc), v[i].op, 32'h0, 32'h0);
            checks++;
            if (alu_select !== v[i].sel) begin
                errors++;
                $display("FAIL dec_sel[%0d]: got %0d expected %0d", i, alu_select, v[i].sel);
            end
            checks++;
            if (sel_valid !== v[i].vld) begin
                errors++;
                $display("FAIL dec_valid[%0d]: got %b expected %b", i, sel_valid, v[i].vld);
            end
            checks++;
            if (illegal !== v[i].ill) begin
                errors++;
                $display("FAIL dec_illegal[%0d]: got %b expected %b", i, illegal, v[i].ill);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({sel_valid, illegal, stall} !== 3'b000) begin
            errors++;
            $display("FAIL dec_pulse: got %b expected 000", {sel_valid, illegal, stall});
        end
    endtask

    // Shared body for lists of M-ops: result, md_done latency and stall length
    task automatic run_md_list(input string tag, input md_vec_t v);
        int          lat;
        int          stl;
        logic [31:0] res;
        send(mk(7'b0000001, v.f3, 7'b0110011), 2'b10, v.a, v.b);
        checks++;
        if ({sel_valid, illegal} !== 2'b00) begin
            errors++;
            $display("FAIL %s_flags: got %b expected 00", tag, {sel_valid, illegal});
        end
        run_md(lat, stl, res);
        checks++;
        if (res !== v.res) begin
            errors++;
            $display("FAIL %s_result: got %h expected %h", tag, res, v.res);
        end
        checks++;
        if (lat !== int'(v.lat)) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", tag, lat, v.lat);
        end
        checks++;
        if (stl !== int'(v.lat)) begin
            errors++;
            $display("FAIL %s_stall: got %0d expected %0d", tag, stl, v.lat);
        end
        last_res = v.res;
    endtask

    task automatic test_mul();
        md_vec_t v [5];
        v[0] = '{3'b000, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 8'd33};
        v[1] = '{3'b001, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 8'd33};
        v[2] = '{3'b011, 32'hFFFFFFFF, 32'h00000003, 32'h00000002, 8'd33};
        v[3] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd33};
        v[4] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 8'd33};
        for (int i = 0; i < 5; i++) run_md_list($sformatf("mul%0d", i), v[i]);
        @(posedge clk);
        #1;
        checks++;
        if (md_done !== 1'b0 || md_result !== last_res) begin
            errors++;
            $display("FAIL md_hold: got done=%b res=%h expected done=0 res=%h",
                     md_done, md_result, last_res);
        end
    endtask

    task automatic test_div();
        md_vec_t v [10];
        v[0] = '{3'b100, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 8'd2};
        v[1] = '{3'b110, 32'h00000007, 32'h00000000, 32'h00000007, 8'd2};
        v[2] = '{3'b101, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 8'd2};
        v[3] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd2};
        v[4] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd2};
        v[5] = '{3'b101, 32'd100,      32'd7,        32'd14,       8'd33};
        v[6] = '{3'b111, 32'd100,      32'd7,        32'd2,        8'd33};
        v[7] = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 8'd33};
        v[8] = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 8'd33};
        v[9] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd33};
        for (int i = 0; i < 10; i++) run_md_list($sformatf("div%0d", i), v[i]);
    endtask

    task automatic test_flush();
        int seen = 0;
        send(mk(7'b0000001, 3'b000, 7'b0110011), 2'b10, 32'd9, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_stall: got %b expected 1", stall);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b expected 0", stall);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (md_done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || md_result !== last_res) begin
            errors++;
            $display("FAIL flush_no_done: got done_count=%0d res=%h expected 0 res=%h",
                     seen, md_result, last_res);
        end
        @(negedge clk);
        instr    = mk(7'b0000000, 3'b000, 7'b0110011);
        alu_op   = 2'b10;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({sel_valid, illegal} !== 2'b00) begin
            errors++;
            $display("FAIL flush_base_accept: got %b expected 00", {sel_valid, illegal});
        end
        instr = mk(7'b0000001, 3'b000, 7'b0110011);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_m_accept: got stall=%b expected 0", stall);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          stl;
        logic [31:0] res;
        send(mk(7'b0000001, 3'b101, 7'b0110011), 2'b10, 32'd100, 32'd7);
        run_md(lat, stl, res);
        checks++;
        if (res !== 32'd14 || lat !== 33) begin
            errors++;
            $display("FAIL b2b_first: got res=%h lat=%0d expected res=0000000e lat=33", res, lat);
        end
        // Issue in the md_done cycle itself
        instr    = mk(7'b0000001, 3'b111, 7'b0110011);
        alu_op   = 2'b10;
        op_a     = 32'd100;
        op_b     = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got stall=%b expected 1", stall);
        end
        run_md(lat, stl, res);
        checks++;
        if (res !== 32'd2 || lat !== 33) begin
            errors++;
            $display("FAIL b2b_second: got res=%h lat=%0d expected res=00000002 lat=33", res, lat);
        end
        last_res = 32'd2;
    endtask

    task automatic test_reset_mid_run();
        int          lat;
        int          stl;
        logic [31:0] res;
        send(mk(7'b0000001, 3'b000, 7'b0110011), 2'b10, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_select, sel_valid, illegal, stall, md_done} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_ctrl: got %h expected 00",
                     {alu_select, sel_valid, illegal, stall, md_done});
        end
        checks++;
        if (md_result !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_result: got %h expected 00000000", md_result);
        end
        @(negedge clk);
        rst = 1'b0;
        send(mk(7'b0000001, 3'b001, 7'b0110011), 2'b10, 32'hFFFFFFFF, 32'd3);
        run_md(lat, stl, res);
        checks++;
        if (res !== 32'hFFFFFFFF || lat !== 33 || stl !== 33) begin
            errors++;
            $display("FAIL post_reset_mulh: got res=%h lat=%0d stall=%0d expected FFFFFFFF 33 33",
                     res, lat, stl);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        instr    = 32'h0;
        alu_op   = 2'b00;
        op_a     = 32'h0;
        op_b     = 32'h0;
        flush    = 1'b0;
        test_reset();
        test_base_decode();
        test_mul();
        test_div();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
